imem_fetch_unit: RTL and testbench

Parametrised instruction store and fetch stage for the single-cycle RISC-V core, replacing the fixed 64-word, initial-block-loaded instruction memory. It is programmed at run time through a valid/ready loader port. It returns a registered instruction with a valid flag, a fault flag and decoded fields. Unloaded locations read as NOP. It sits between the PC register and the control/register-file decode.

---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_loader.sv | 76 +++++++
 rtl/imem_fetch_unit.sv | 133 +++++++++++++
 tb/tb_imem_fetch_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction store / fetch stage.
// Field positions follow the base RISC-V 32-bit instruction layout.
package imem_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      READY
   } imem_state_t;

   localparam int unsigned OPCODE_LSB = 0;
   localparam int unsigned OPCODE_W   = 7;
   localparam int unsigned RD_LSB     = 7;
   localparam int unsigned RD_W       = 5;
   localparam int unsigned FUNC3_LSB  = 12;
   localparam int unsigned FUNC3_W    = 3;
   localparam int unsigned RS1_LSB    = 15;
   localparam int unsigned RS1_W      = 5;
   localparam int unsigned RS2_LSB    = 20;
   localparam int unsigned RS2_W      = 5;
   localparam int unsigned FUNC7_LSB  = 25;
   localparam int unsigned FUNC7_W    = 7;

endpackage

// File: rtl/imem_loader.sv
// Program-load FSM: tracks IDLE/LOAD/READY, counts accepted words and
// produces the array write enable/index plus the valid-bit clear strobe.
module imem_loader
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1),
   parameter int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ld_start,
   input  logic             i_ld_valid,
   input  logic             i_ld_last,
   output logic             o_ld_ready,
   output logic             o_loaded,
   output logic [CNT_W-1:0] o_ld_count,
   output logic             o_we,
   output logic [IDX_W-1:0] o_widx,
   output logic             o_clear
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

   imem_state_t      r_state;
   imem_state_t      w_state_d;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_d;
         r_count <= w_count_d;
      end
   end

   always_comb begin
      w_state_d  = r_state;
      w_count_d  = r_count;
      o_we       = 1'b0;
      o_clear    = 1'b0;
      o_ld_ready = 1'b0;
      o_loaded   = 1'b0;

      unique case (r_state)
         IDLE: ;
         LOAD: begin
            o_ld_ready = 1'b1;
            // A restart discards any word offered in the same cycle.
            if (i_ld_valid && !i_ld_start) begin
               o_we      = 1'b1;
               w_count_d = r_count + CNT_W'(1);
               if (i_ld_last || (r_count == LAST_IDX)) begin
                  w_state_d = READY;
               end
            end
         end
         READY: o_loaded = 1'b1;
         default: w_state_d = IDLE;
      endcase

      if (i_ld_start) begin
         w_state_d = LOAD;
         w_count_d = '0;
         o_clear   = 1'b1;
      end
   end

   // Writes only happen in LOAD, where the count never exceeds DEPTH-1.
   assign o_widx     = r_count[IDX_W-1:0];
   assign o_ld_count = r_count;

endmodule

// File: rtl/imem_fetch_unit.sv
// Run-time loadable instruction store with a registered, decoded fetch port.
// Define IMEM_BOUNDS_CHECK_EN to fault fetches beyond DEPTH instead of wrapping.
module imem_fetch_unit
   import imem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   input  logic              fetch_req,
   output logic              inst_valid,
   output logic [31:0]       instruction,
   output logic [6:0]        opcode,
   output logic [4:0]        rd,
   output logic [2:0]        func3,
   output logic [4:0]        rs1,
   output logic [4:0]        rs2,
   output logic [6:0]        func7,
   output logic              fault,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [31:0]       ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              loaded,
   output logic [CNT_W-1:0]  ld_count
);

   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned WORD_W = ADDR_W - 2;

   logic [31:0]      r_mem [DEPTH];
   logic [DEPTH-1:0] r_wvalid;
   logic             r_inst_valid;
   logic             r_fault;
   logic [31:0]      r_inst;

   logic             w_we;
   logic [IDX_W-1:0] w_widx;
   logic             w_clear;
   logic             w_fetch;
   logic [IDX_W-1:0] w_idx;
   logic             w_oob;
   logic             w_misaligned;
   logic             w_bad;
   logic [31:0]      w_rdata;

   imem_loader #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W),
      .IDX_W (IDX_W)
   ) u_loader (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_ld_start (ld_start),
      .i_ld_valid (ld_valid),
      .i_ld_last  (ld_last),
      .o_ld_ready (ld_ready),
      .o_loaded   (loaded),
      .o_ld_count (ld_count),
      .o_we       (w_we),
      .o_widx     (w_widx),
      .o_clear    (w_clear)
   );

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_widx] <= ld_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wvalid <= '0;
      end else if (w_clear) begin
         r_wvalid <= '0;
      end else if (w_we) begin
         r_wvalid[w_widx] <= 1'b1;
      end
   end

`ifdef IMEM_BOUNDS_CHECK_EN
   logic [WORD_W-1:0] w_word;
   assign w_word = pc[ADDR_W-1:2];
   assign w_oob  = (w_word >= WORD_W'(DEPTH));
   assign w_idx  = w_word[IDX_W-1:0];
`else
   // Upper address bits are ignored so fetches wrap modulo DEPTH words.
   logic w_unused_pc;
   assign w_unused_pc = ^pc[ADDR_W-1:IDX_W+2];
   assign w_oob       = 1'b0;
   assign w_idx       = pc[IDX_W+1:2];
`endif

   assign w_fetch      = fetch_req && loaded;
   assign w_misaligned = (pc[1:0] != 2'b00);
   assign w_bad        = w_misaligned || w_oob;

   always_comb begin
      w_rdata = NOP_INST;
      if (!w_bad && r_wvalid[w_idx]) begin
         w_rdata = r_mem[w_idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inst_valid <= 1'b0;
         r_fault      <= 1'b0;
         r_inst       <= NOP_INST;
      end else begin
         r_inst_valid <= w_fetch;
         r_fault      <= w_fetch && w_bad;
         if (w_fetch) begin
            r_inst <= w_rdata;
         end
      end
   end

   assign inst_valid  = r_inst_valid;
   assign fault       = r_fault;
   assign instruction = r_inst;
   assign opcode      = r_inst[OPCODE_LSB +: OPCODE_W];
   assign rd          = r_inst[RD_LSB +: RD_W];
   assign func3       = r_inst[FUNC3_LSB +: FUNC3_W];
   assign rs1         = r_inst[RS1_LSB +: RS1_W];
   assign rs2         = r_inst[RS2_LSB +: RS2_W];
   assign func7       = r_inst[FUNC7_LSB +: FUNC7_W];

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit with default parameters (DEPTH=64).
module tb_imem_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        fetch_req;
   logic        inst_valid;
   logic [31:0] instruction;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  func3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  func7;
   logic        fault;
   logic        ld_start;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic        loaded;
   logic [6:0]  ld_count;

   int n_checks = 0;
   int n_errors = 0;

   imem_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .fetch_req   (fetch_req),
      .inst_valid  (inst_valid),
      .instruction (instruction),
      .opcode      (opcode),
      .rd          (rd),
      .func3       (func3),
      .rs1         (rs1),
      .rs2         (rs2),
      .func7       (func7),
      .fault       (fault),
      .ld_start    (ld_start),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .ld_ready    (ld_ready),
      .loaded      (loaded),
      .ld_count    (ld_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single fetch; result checked one cycle later.
   task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp_inst,
                        input logic exp_fault);
      pc        = addr;
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      check({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
      check({tag, "_inst"}, instruction, exp_inst);
      check({tag, "_fault"}, {31'b0, fault}, {31'b0, exp_fault});
   endtask

   task automatic load_word(input logic [31:0] data, input logic last);
      ld_valid = 1'b1;
      ld_data  = data;
      ld_last  = last;
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      pc        = '0;
      fetch_req = 1'b0;
      ld_start  = 1'b0;
      ld_valid  = 1'b0;
      ld_data   = '0;
      ld_last   = 1'b0;
      step();
      step();
      rst = 1'b0;

      check("rst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_inst", instruction, NOP);
      check("rst_opcode", {25'b0, opcode}, 32'h13);
      check("rst_rd", {27'b0, rd}, 32'd0);
      check("rst_fault", {31'b0, fault}, 32'd0);
      check("rst_ready", {31'b0, ld_ready}, 32'd0);
      check("rst_loaded", {31'b0, loaded}, 32'd0);
      check("rst_count", {25'b0, ld_count}, 32'd0);

      // Fetch in IDLE is ignored.
      pc        = 32'd0;
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      check("idle_valid", {31'b0, inst_valid}, 32'd0);
      check("idle_inst", instruction, NOP);

      // Three-word program.
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      check("ld_ready", {31'b0, ld_ready}, 32'd1);
      check("ld_count0", {25'b0, ld_count}, 32'd0);
      load_word(32'hfe010113, 1'b0);
      load_word(32'h00812e23, 1'b0);
      check("loaded_early", {31'b0, loaded}, 32'd0);
      load_word(32'h02010413, 1'b1);
      check("loaded", {31'b0, loaded}, 32'd1);
      check("ld_ready_off", {31'b0, ld_ready}, 32'd0);
      check("ld_count3", {25'b0, ld_count}, 32'd3);

      // Back-to-back fetches.
      fetch("pc4", 32'd4, 32'h00812e23, 1'b0);
      check("pc4_opcode", {25'b0, opcode}, 32'h23);
      check("pc4_rd", {27'b0, rd}, 32'h1c);
      check("pc4_func3", {29'b0, func3}, 32'd2);
      check("pc4_rs1", {27'b0, rs1}, 32'd2);
      check("pc4_rs2", {27'b0, rs2}, 32'd8);
      check("pc4_func7", {25'b0, func7}, 32'd0);
      fetch("pc12", 32'd12, NOP, 1'b0);
      fetch("pc6", 32'd6, NOP, 1'b1);
`ifdef IMEM_BOUNDS_CHECK_EN
      fetch("pc256", 32'd256, NOP, 1'b1);
`else
      fetch("pc256", 32'd256, 32'hfe010113, 1'b0);
`endif
      fetch("pc0", 32'd0, 32'hfe010113, 1'b0);

      // Idle cycle: no valid, no fault, instruction held.
      step();
      check("hold_valid", {31'b0, inst_valid}, 32'd0);
      check("hold_fault", {31'b0, fault}, 32'd0);
      check("hold_inst", instruction, 32'hfe010113);

      // Fetch alongside ld_start in READY is still served.
      ld_start = 1'b1;
      fetch("pc8_start", 32'd8, 32'h02010413, 1'b0);
      ld_start = 1'b0;
      check("restart_ready", {31'b0, ld_ready}, 32'd1);
      check("restart_loaded", {31'b0, loaded}, 32'd0);
      check("restart_count", {25'b0, ld_count}, 32'd0);

      // Fill all 64 words without ld_last.
      for (int i = 0; i < 63; i++) begin
         load_word(32'h1000_0000 + 32'(i), 1'b0);
      end
      check("fill63_ready", {31'b0, ld_ready}, 32'd1);
      check("fill63_count", {25'b0, ld_count}, 32'd63);
      load_word(32'h1000_003f, 1'b0);
      check("fill64_loaded", {31'b0, loaded}, 32'd1);
      check("fill64_count", {25'b0, ld_count}, 32'd64);
      load_word(32'hdead_beef, 1'b0);
      check("fill65_count", {25'b0, ld_count}, 32'd64);
      fetch("pc252", 32'd252, 32'h1000_003f, 1'b0);
      fetch("pc12b", 32'd12, 32'h1000_0003, 1'b0);

      // Restart mid-load with a simultaneous handshake.
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      load_word(32'haaaa_0000, 1'b0);
      load_word(32'haaaa_0001, 1'b0);
      ld_start = 1'b1;
      load_word(32'hbbbb_0000, 1'b0);
      ld_start = 1'b0;
      check("midstart_count", {25'b0, ld_count}, 32'd0);
      check("midstart_ready", {31'b0, ld_ready}, 32'd1);
      load_word(32'hcccc_0000, 1'b1);
      check("midstart_loaded", {31'b0, loaded}, 32'd1);
      check("midstart_count1", {25'b0, ld_count}, 32'd1);
      fetch("mid_pc0", 32'd0, 32'hcccc_0000, 1'b0);
      fetch("mid_pc4", 32'd4, NOP, 1'b0);
      fetch("mid_pc8", 32'd8, NOP, 1'b0);

      // Asynchronous reset mid-load.
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      load_word(32'heeee_0000, 1'b0);
      check("prerst_count", {25'b0, ld_count}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_count", {25'b0, ld_count}, 32'd0);
      check("arst_ready", {31'b0, ld_ready}, 32'd0);
      check("arst_loaded", {31'b0, loaded}, 32'd0);
      check("arst_inst", instruction, NOP);
      step();
      rst = 1'b0;
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      load_word(32'hdddd_0000, 1'b1);
      check("reload_count", {25'b0, ld_count}, 32'd1);
      fetch("rl_pc0", 32'd0, 32'hdddd_0000, 1'b0);
      fetch("rl_pc4", 32'd4, NOP, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
